// File: rtl/btn_enc_db_pkg.sv
// btn_enc_db_pkg: shared direction codes, channel indices and default timing
package btn_enc_db_pkg;
    typedef enum logic [1:0] {
        UP    = 2'b00,
        DOWN  = 2'b01,
        LEFT  = 2'b10,
        RIGHT = 2'b11
    } dir_t;
    localparam int BTN_L = 0;
    localparam int BTN_R = 1;
    localparam int BTN_U = 2;
    localparam int BTN_D = 3;
    localparam int BTN_C = 4;
    localparam int DB_CYCLES_DEF = 16;
    localparam int LONG_CYCLES_DEF = 1024;
endpackage

// File: rtl/btn_enc_db_debounce_ch.sv
// btn_debounce_ch: one button channel, sync + debounce + press/long (auto-repeat with BTN_AUTO_REPEAT_EN)
module btn_debounce_ch #(
    parameter int DB_CYCLES     = 16,
    parameter int LONG_CYCLES   = 1024,
    parameter int REPEAT_CYCLES = 256,
    parameter int CNT_W         = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic stable,
    output logic press,
    output logic long_press
);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    if (DB_CYCLES < 2 || LONG_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_cycles
        $error("btn_debounce_ch: cycle parameters must be >= 2");
    end
    logic s1, s2, rise_q, flip;
    logic [CNT_W-1:0] db_cnt, hold_cnt;
    assign flip = (s2 != stable) && (db_cnt == DB_LAST);
    // synchronise the pin, debounce it and track how long it has been held
    always_ff @(posedge clk) begin
        if (rst) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            stable   <= 1'b0;
            rise_q   <= 1'b0;
            db_cnt   <= '0;
            hold_cnt <= '0;
        end else begin
            s1       <= btn;
            s2       <= s1;
            db_cnt   <= (s2 == stable || db_cnt == DB_LAST) ? '0 : db_cnt + 1'b1;
            stable   <= flip ? s2 : stable;
            rise_q   <= flip & s2;
            hold_cnt <= !stable ? '0 : (hold_cnt == LONG_LAST) ? hold_cnt : hold_cnt + 1'b1;
        end
    end
    assign long_press = stable && (hold_cnt == LONG_LAST);
`ifdef BTN_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    logic [CNT_W-1:0] rpt_cnt;
    // repeat phase counter, zero marks a repeat pulse while the long press lasts
    always_ff @(posedge clk) begin
        if (rst || !long_press) rpt_cnt <= '0;
        else rpt_cnt <= (rpt_cnt == RPT_LAST) ? '0 : rpt_cnt + 1'b1;
    end
    assign press = rise_q || (long_press && rpt_cnt == '0);
`else
    assign press = rise_q;
`endif
endmodule

// File: rtl/btn_enc_db.sv
// btn_enc_db: debounced button bank with press/long outputs and direction encoder (option BTN_AUTO_REPEAT_EN)
module btn_enc_db
    import btn_enc_db_pkg::*;
#(
    parameter int NUM_BTN       = 5,
    parameter int DB_CYCLES     = DB_CYCLES_DEF,
    parameter int LONG_CYCLES   = LONG_CYCLES_DEF,
    parameter int REPEAT_CYCLES = 256,
    parameter int CNT_W         = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_i,
    output logic [NUM_BTN-1:0] btn_stable_o,
    output logic [NUM_BTN-1:0] press_o,
    output logic [NUM_BTN-1:0] long_o,
    output logic               move_en_o,
    output logic [1:0]         direct_o,
    output logic               press_vali_o
);
    if (NUM_BTN < BTN_D + 1) begin : g_bad_num
        $error("btn_enc_db: NUM_BTN must cover the four direction buttons");
    end
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DB_CYCLES    (DB_CYCLES),
            .LONG_CYCLES  (LONG_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES),
            .CNT_W        (CNT_W)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .btn       (btn_i[i]),
            .stable    (btn_stable_o[i]),
            .press     (press_o[i]),
            .long_press(long_o[i])
        );
    end
    logic move_en_d;
    dir_t direct_d;
    // exactly one held direction button selects its code, anything else parks on DOWN
    always_comb begin
        move_en_d = $onehot(btn_stable_o[BTN_D:BTN_L]);
        direct_d  = !move_en_d ? DOWN :
                    btn_stable_o[BTN_L] ? LEFT :
                    btn_stable_o[BTN_R] ? RIGHT :
                    btn_stable_o[BTN_U] ? UP : DOWN;
    end
    // direction outputs trail the debounced levels by one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            move_en_o <= 1'b0;
            direct_o  <= DOWN;
        end else begin
            move_en_o <= move_en_d;
            direct_o  <= direct_d;
        end
    end
    assign press_vali_o = |btn_stable_o;
endmodule

// File: tb/tb_btn_enc_db.sv
// tb_btn_enc_db: directed vector table plus randomized run against a cycle-level reference model
module tb_btn_enc_db;
    import btn_enc_db_pkg::*;
    localparam int NB = 5, DB = 4, LONG = 8, RPT = 3;
`ifdef BTN_AUTO_REPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1;
    logic [NB-1:0] btn_i = '1;
    logic [NB-1:0] btn_stable_o, press_o, long_o;
    logic move_en_o, press_vali_o;
    logic [1:0] direct_o;
    int n_chk = 0, n_fail = 0;

    btn_enc_db #(.NUM_BTN(NB), .DB_CYCLES(DB), .LONG_CYCLES(LONG), .REPEAT_CYCLES(RPT), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .btn_i(btn_i), .btn_stable_o(btn_stable_o), .press_o(press_o),
        .long_o(long_o), .move_en_o(move_en_o), .direct_o(direct_o), .press_vali_o(press_vali_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: inputs delayed by two samples, a flip after DB consecutive
    // differing samples, press/long/repeat derived from the age of the current hold
    logic [NB-1:0] m_st = '0, m_s1 = '0, m_s2 = '0, m_press = '0, m_long = '0;
    logic m_move = 1'b0;
    logic [1:0] m_dir = DOWN;
    int run[NB], age[NB];

    task automatic model_step();
        logic [NB-1:0] old;
        if (rst) begin
            m_st = '0; m_s1 = '0; m_s2 = '0; m_press = '0; m_long = '0;
            m_move = 1'b0; m_dir = DOWN;
            for (int i = 0; i < NB; i++) begin run[i] = 0; age[i] = 0; end
        end else begin
            old = m_st;
            m_move = $countones(old[3:0]) == 1;
            m_dir = !m_move ? DOWN : old[BTN_L] ? LEFT : old[BTN_R] ? RIGHT : old[BTN_U] ? UP : DOWN;
            for (int i = 0; i < NB; i++) begin
                run[i] = (m_s2[i] != old[i]) ? run[i] + 1 : 0;
                if (run[i] == DB) begin m_st[i] = m_s2[i]; run[i] = 0; end
                age[i] = old[i] ? age[i] + 1 : 0;
                m_long[i] = m_st[i] && age[i] >= LONG - 1;
                m_press[i] = (m_st[i] && !old[i]) || (AR && m_long[i] && ((age[i] - (LONG - 1)) % RPT) == 0);
            end
            m_s2 = m_s1;
            m_s1 = btn_i;
        end
    endtask

    initial forever begin
        @(negedge clk);
        model_step();
        chk("mdl.stable", 8'(btn_stable_o), 8'(m_st));
        chk("mdl.press", 8'(press_o), 8'(m_press));
        chk("mdl.long", 8'(long_o), 8'(m_long));
        chk("mdl.move_en", 8'(move_en_o), 8'(m_move));
        chk("mdl.direct", 8'(direct_o), 8'(m_dir));
        chk("mdl.vali", 8'(press_vali_o), 8'(|m_st));
    end

    typedef struct {
        logic r;
        logic [NB-1:0] b;
        int n;
        logic [NB-1:0] st, pr, lg;
        logic mv;
        logic [1:0] dr;
    } vec_t;
    vec_t v[$];

    task automatic add(input logic r, input logic [NB-1:0] b, input int n, input logic [NB-1:0] st,
                       input logic [NB-1:0] pr, input logic [NB-1:0] lg, input logic mv, input logic [1:0] dr);
        v.push_back('{r, b, n, st, pr, lg, mv, dr});
    endtask

    initial begin
        logic [NB-1:0] p4, p1, c;
        p4 = AR ? 5'b10000 : 5'b00000;
        p1 = AR ? 5'b00010 : 5'b00000;
        c = 5'(1 << BTN_C);
        // reset with all pins held, then release: all rise 6 cycles later
        add(1, 5'b11111, 3, 0, 0, 0, 0, DOWN);
        add(0, 5'b11111, 5, 0, 0, 0, 0, DOWN);
        add(0, 5'b11111, 1, 5'b11111, 5'b11111, 0, 0, DOWN);
        add(0, 5'b11111, 1, 5'b11111, 0, 0, 0, DOWN);
        add(0, 5'b00000, 5, 5'b11111, 0, 0, 0, DOWN);
        add(0, 5'b00000, 1, 0, 0, 0, 0, DOWN);
        add(0, 5'b00000, 2, 0, 0, 0, 0, DOWN);
        // bounce on L, then clean press
        add(0, 5'b00001, 1, 0, 0, 0, 0, DOWN);
        add(0, 5'b00000, 1, 0, 0, 0, 0, DOWN);
        add(0, 5'b00001, 1, 0, 0, 0, 0, DOWN);
        add(0, 5'b00000, 1, 0, 0, 0, 0, DOWN);
        add(0, 5'b00001, 5, 0, 0, 0, 0, DOWN);
        add(0, 5'b00001, 1, 5'b00001, 5'b00001, 0, 0, DOWN);
        add(0, 5'b00001, 1, 5'b00001, 0, 0, 1, LEFT);
        add(0, 5'b00000, 5, 5'b00001, 0, 0, 1, LEFT);
        add(0, 5'b00000, 1, 0, 0, 0, 1, LEFT);
        add(0, 5'b00000, 1, 0, 0, 0, 0, DOWN);
        // U and D together
        add(0, 5'b01100, 5, 0, 0, 0, 0, DOWN);
        add(0, 5'b01100, 1, 5'b01100, 5'b01100, 0, 0, DOWN);
        add(0, 5'b01100, 1, 5'b01100, 0, 0, 0, DOWN);
        add(0, 5'b00000, 5, 5'b01100, 0, 0, 0, DOWN);
        add(0, 5'b00000, 2, 0, 0, 0, 0, DOWN);
        // centre held 20 cycles: long press and its release
        add(0, c, 5, 0, 0, 0, 0, DOWN);
        add(0, c, 1, c, c, 0, 0, DOWN);
        add(0, c, 6, c, 0, 0, 0, DOWN);
        add(0, c, 1, c, p4, c, 0, DOWN);
        add(0, c, 7, c, 0, c, 0, DOWN);
        add(0, 5'b00000, 5, c, p4, c, 0, DOWN);
        add(0, 5'b00000, 1, 0, 0, 0, 0, DOWN);
        // R held into auto-repeat
        add(0, 5'b00010, 5, 0, 0, 0, 0, DOWN);
        add(0, 5'b00010, 1, 5'b00010, 5'b00010, 0, 0, DOWN);
        add(0, 5'b00010, 1, 5'b00010, 0, 0, 1, RIGHT);
        add(0, 5'b00010, 5, 5'b00010, 0, 0, 1, RIGHT);
        add(0, 5'b00010, 1, 5'b00010, p1, 5'b00010, 1, RIGHT);
        add(0, 5'b00010, 2, 5'b00010, 0, 5'b00010, 1, RIGHT);
        add(0, 5'b00010, 1, 5'b00010, p1, 5'b00010, 1, RIGHT);
        add(0, 5'b00000, 2, 5'b00010, 0, 5'b00010, 1, RIGHT);
        add(0, 5'b00000, 1, 5'b00010, p1, 5'b00010, 1, RIGHT);
        add(0, 5'b00000, 2, 5'b00010, 0, 5'b00010, 1, RIGHT);
        add(0, 5'b00000, 1, 0, 0, 0, 1, RIGHT);
        add(0, 5'b00000, 1, 0, 0, 0, 0, DOWN);
        // reset in the middle of a long press
        add(0, c, 5, 0, 0, 0, 0, DOWN);
        add(0, c, 1, c, c, 0, 0, DOWN);
        add(0, c, 7, c, p4, c, 0, DOWN);
        add(1, c, 1, 0, 0, 0, 0, DOWN);
        add(1, c, 1, 0, 0, 0, 0, DOWN);
        add(0, c, 5, 0, 0, 0, 0, DOWN);
        add(0, c, 1, c, c, 0, 0, DOWN);
        add(0, 5'b00000, 6, 0, 0, 0, 0, DOWN);
        foreach (v[k]) begin
            rst = v[k].r;
            btn_i = v[k].b;
            repeat (v[k].n) @(negedge clk);
            chk($sformatf("v%0d.stable", k), 8'(btn_stable_o), 8'(v[k].st));
            chk($sformatf("v%0d.press", k), 8'(press_o), 8'(v[k].pr));
            chk($sformatf("v%0d.long", k), 8'(long_o), 8'(v[k].lg));
            chk($sformatf("v%0d.move_en", k), 8'(move_en_o), 8'(v[k].mv));
            chk($sformatf("v%0d.direct", k), 8'(direct_o), 8'(v[k].dr));
            #1;
        end
        // randomized holds, single-cycle glitches and occasional resets
        for (int t = 0; t < 400; t++) begin
            int sel;
            sel = $urandom_range(0, 19);
            if (sel == 0) begin
                rst = 1'b1;
                repeat ($urandom_range(1, 2)) @(negedge clk);
                #1 rst = 1'b0;
            end else if (sel < 5) begin
                btn_i = btn_i ^ 5'(1 << $urandom_range(0, NB - 1));
                @(negedge clk);
                #1 btn_i = btn_i ^ 5'(1 << $urandom_range(0, NB - 1));
                repeat ($urandom_range(1, 4)) @(negedge clk);
                #1;
            end else begin
                btn_i = 5'($urandom);
                repeat ($urandom_range(1, 20)) @(negedge clk);
                #1;
            end
        end
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/btn_enc_db.md
Name: btn_enc_db

Overview:
Parametrised successor to the board button encoder. It debounces N raw push-button inputs and produces several outputs:
- one-cycle press pulses per button;
- a long-press level per button;
- a registered move-enable/direction code from the four direction buttons.

It sits between the board button pins and the game control logic. Downstream long-press reset generation uses long_o of the centre button.

Parameters:
NUM_BTN, 5, number of button channels; must be >= 4; channels 0..3 are L,R,U,D and channel 4 is centre
DB_CYCLES, 16, consecutive stable-different samples needed before the debounced state flips; must be >= 2
LONG_CYCLES, 1024, debounced hold cycles before long_o asserts; must be >= 2
REPEAT_CYCLES, 256, auto-repeat period once long-press is reached (used only with the macro); must be >= 2
CNT_W, 16, counter width; must hold max(DB_CYCLES, LONG_CYCLES, REPEAT_CYCLES)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
btn_i  in  NUM_BTN  raw button pins (asynchronous to clk, bouncy)
btn_stable_o  out  NUM_BTN  debounced button level
press_o  out  NUM_BTN  one-cycle pulse per debounced press (and per repeat, see Optional Feature)
long_o  out  NUM_BTN  high while the button has been held >= LONG_CYCLES debounced cycles
move_en_o  out  1  exactly one direction button is held (registered)
direct_o  out  2  direction code (registered)
press_vali_o  out  1  OR of btn_stable_o

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. While rst is high at a clk edge, every counter, synchronizer flop and output register clears.
- Reset values: btn_stable_o=0, press_o=0, long_o=0, move_en_o=0, direct_o=DOWN. press_vali_o=0 follows.
- Synchroniser:
  - Each btn_i bit passes through a 2-flop synchroniser (s1, s2) before debounce.
  - Latency from a raw edge to the debounce input is 2 cycles.
- Debounce (per channel, counter db_cnt):
  - If s2 == stable: db_cnt <= 0.
  - Else if db_cnt == DB_CYCLES-1: stable <= s2 and db_cnt <= 0.
  - Else: db_cnt <= db_cnt+1.
  - A single-cycle glitch therefore resets progress.
  - A clean edge reaches btn_stable_o 2+DB_CYCLES cycles after it appears on btn_i.
- Press pulse:
  - press_o[i] is high for exactly the one cycle in which stable[i] goes 0->1 (registered, same cycle as the btn_stable_o rise).
  - Release generates no pulse.
- Long press (per channel, counter hold_cnt):
  - Cleared while stable[i]=0.
  - Increments while stable[i]=1 and saturates at LONG_CYCLES-1.
  - long_o[i] = stable[i] && hold_cnt == LONG_CYCLES-1.
  - long_o therefore rises LONG_CYCLES-1 cycles after the btn_stable_o rise.
  - long_o falls in the same cycle that btn_stable_o falls.
  - No wrap-around.
- Direction encode (registered, 1 cycle after btn_stable_o), on stable[3:0]:
  - only L -> move_en=1, LEFT
  - only R -> move_en=1, RIGHT
  - only U -> move_en=1, UP
  - only D -> move_en=1, DOWN
  - any other pattern (none, or two or more held) -> move_en=0, DOWN
  - Channels >= 4 are ignored by the encoder.
- Simultaneous events:
  - Channels are fully independent.
  - Several press_o bits may pulse in the same cycle.
- Reset mid-operation:
  - A button still physically held after rst deasserts is debounced again from scratch.
  - It yields a fresh press_o after 2+DB_CYCLES cycles.

Optional Feature:
Macro BTN_AUTO_REPEAT_EN.
- Defined:
  - A per-channel rpt_cnt runs while long_o[i]=1.
  - press_o[i] also pulses on the first cycle long_o[i] is high.
  - It then pulses every REPEAT_CYCLES cycles while long_o[i] stays high.
  - rpt_cnt clears when long_o[i] falls.
- Not defined:
  - rpt_cnt logic is absent.
  - press_o pulses only on the debounced rising edge.

Decomposition:
- Shared define header holds:
  - direction codes UP=2'b00, DOWN=2'b01, LEFT=2'b10, RIGHT=2'b11;
  - channel indices BTN_L=0, BTN_R=1, BTN_U=2, BTN_D=3, BTN_C=4;
  - default DB_CYCLES and LONG_CYCLES constants.
- One sub-module: btn_debounce_ch.
  - Single channel: synchroniser, db_cnt, hold_cnt, rpt_cnt, press and long logic.
  - Instantiated NUM_BTN times in a generate loop.
  - The top holds only the direction encoder and the OR.

Test Plan (DB_CYCLES=4, LONG_CYCLES=8, REPEAT_CYCLES=3):
- rst held 3 cycles with btn_i=5'b11111 -> all outputs 0, direct_o=DOWN; after release of rst, btn_stable_o=5'b11111 exactly 6 cycles later, press_o=5'b11111 pulses that same cycle.
- btn_i[0] bounces 1,0,1,0 at 1-cycle spacing, then stays 1 -> no press_o during the bounce; one press_o[0] pulse 6 cycles after the final rise; next cycle move_en_o=1, direct_o=LEFT.
- btn_i[2] and btn_i[3] pressed together -> press_o[2] and press_o[3] pulse in the same cycle; move_en_o=0, direct_o=DOWN.
- btn_i[4] held 20 cycles -> long_o[4] rises 7 cycles after btn_stable_o[4]; after release, long_o[4] falls in the same cycle btn_stable_o[4] falls.
- BTN_AUTO_REPEAT_EN defined, btn_i[1] held -> press_o[1] pulses at the debounced edge, at the long_o rise, then every 3 cycles; stops on release. Undefined -> the edge pulse only.
- rst asserted 2 cycles mid-hold with long_o[4]=1 -> long_o and btn_stable_o drop the next edge; press_o[4] re-fires 6 cycles after rst deasserts.
